// File: rtl/router_pkg.sv
// ----------------------------------------------------------------------------
// router_pkg
// Shared types and constants for the 1x3 router receive controller.
//   state_e          : receive FSM states
//   ADDR_INVALID     : header address that selects no FIFO (packet is dropped)
//   TIMEOUT_DEFAULT  : cycles a FIFO may hold unread data before soft reset
//   dest_onehot()    : header address -> per-FIFO strobe (zero for invalid)
// ----------------------------------------------------------------------------
package router_pkg;

   localparam int         NUM_DEST        = 3;
   localparam int         WIDTH_DEFAULT   = 8;
   localparam int         TIMEOUT_DEFAULT = 30;
   localparam logic [1:0] ADDR_INVALID    = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      DROP,
      WAIT_EMPTY,
      LOAD_FIRST,
      LOAD_DATA,
      FULL_STALL,
      CHECK_PARITY
   } state_e;

   // Address 3 maps to no FIFO so any accidental use cannot strobe a write.
   function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [1:0] a);
      logic [NUM_DEST-1:0] oh;
      case (a)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/router_timeout.sv
// ----------------------------------------------------------------------------
// router_timeout
// Per-destination read-timeout watchdog. Counts cycles in which the FIFO
// holds data that is not being read; after TIMEOUT such cycles it issues a
// one-cycle soft reset and restarts the count.
//   clock, resetn : clock, async active-low reset
//   vld           : FIFO holds data (~empty)
//   rd            : destination is reading this cycle
//   fire          : combinational, high on the edge that launches the pulse
//   soft_reset    : registered one-cycle soft-reset pulse
// ----------------------------------------------------------------------------
module router_timeout #(
   parameter int TIMEOUT = 30
) (
   input  logic clock,
   input  logic resetn,
   input  logic vld,
   input  logic rd,
   output logic fire,
   output logic soft_reset
);

   localparam int              CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             soft_reset_q, soft_reset_d;
   logic             stalled;

   // The counter reaches TIMEOUT-1 on the last idle cycle; the pulse is
   // registered on the following edge, TIMEOUT edges after vld rose.
   always_comb begin
      stalled      = vld & ~rd;
      fire         = stalled && (cnt_q == CNT_MAX);
      soft_reset_d = fire;
      cnt_d        = '0;
      if (stalled && !fire) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt_q        <= '0;
         soft_reset_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         soft_reset_q <= soft_reset_d;
      end
   end

   assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_ctrl.sv
// ----------------------------------------------------------------------------
// router_ctrl
// Packet-receive controller for the 1x3 router. Decodes the header address,
// sequences header / payload / parity writes into the selected router_fifo,
// back-pressures the source, checks parity and soft-resets stale FIFOs.
//   clock, resetn : clock, async active-low reset
//   pkt_valid     : high for header and payload, low on the parity byte
//   data_in       : source byte; header is [7:2] length, [1:0] address
//   fifo_full     : per-FIFO full flag
//   fifo_empty    : per-FIFO empty flag
//   read_enb      : per-destination read strobe (timeout tracking only)
//   dout          : registered byte broadcast to all FIFOs
//   write_enb     : registered one-hot FIFO write strobe
//   lfd_state     : high while in LOAD_FIRST (FIFO tags the next write)
//   busy          : source must hold data_in / pkt_valid while high
//   vld_out       : ~fifo_empty
//   soft_reset    : one-cycle per-FIFO soft reset on read timeout
//   err           : parity mismatch of the last packet
// ----------------------------------------------------------------------------
module router_ctrl
   import router_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             pkt_valid,
   input  logic [WIDTH-1:0] data_in,
   input  logic [2:0]       fifo_full,
   input  logic [2:0]       fifo_empty,
   input  logic [2:0]       read_enb,
   output logic [WIDTH-1:0] dout,
   output logic [2:0]       write_enb,
   output logic             lfd_state,
   output logic             busy,
   output logic [2:0]       vld_out,
   output logic [2:0]       soft_reset,
   output logic             err
);

   state_e           state_q, state_d;
   logic [1:0]       addr_q, addr_d;
   logic [WIDTH-1:0] hdr_q, hdr_d;
   logic [WIDTH-1:0] par_calc_q, par_calc_d;
   logic [WIDTH-1:0] par_rx_q, par_rx_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [2:0]       write_enb_q, write_enb_d;

   logic [2:0]       dest_oh;
   logic             full_sel;
   logic             empty_sel;
   logic             wr_blocked;
   logic             wr_clear;
   logic [2:0]       tmo_fire;
   logic             abort;

   assign vld_out = ~fifo_empty;

   // ---------------------------------------------------------------------
   // Read-timeout watchdogs, one per destination
   // ---------------------------------------------------------------------
   for (genvar i = 0; i < 3; i++) begin : g_tmo
      router_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
         .clock      (clock),
         .resetn     (resetn),
         .vld        (vld_out[i]),
         .rd         (read_enb[i]),
         .fire       (tmo_fire[i]),
         .soft_reset (soft_reset[i])
      );
   end

   // ---------------------------------------------------------------------
   // Selected-FIFO status. Masking by the one-hot keeps address 3 harmless.
   // ---------------------------------------------------------------------
   always_comb begin
      dest_oh    = dest_onehot(addr_q);
      full_sel   = |(fifo_full & dest_oh);
      empty_sel  = |(fifo_empty & dest_oh);
      // A pending write is stuck only while its FIFO is full.
      wr_blocked = (|write_enb_q) && full_sel;
      wr_clear   = !wr_blocked;
      // Only an active packet to the timed-out FIFO is abandoned.
      abort      = (|(tmo_fire & dest_oh)) && (state_q != IDLE) && (state_q != DROP);
   end

   // busy/lfd_state are combinational so the source reacts in the same cycle.
   always_comb begin
      busy = 1'b1;
      case (state_q)
         IDLE, DROP: busy = 1'b0;
         LOAD_DATA:  busy = wr_blocked;
         default:    busy = 1'b1;
      endcase
   end

   assign lfd_state = (state_q == LOAD_FIRST);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      hdr_d      = hdr_q;
      par_calc_d = par_calc_q;
      par_rx_d   = par_rx_q;
      err_d      = err_q;
      dout_d     = dout_q;
      // A write that lands this edge is retired unless a new byte replaces it.
      write_enb_d = wr_clear ? 3'b000 : write_enb_q;

      case (state_q)
         IDLE: begin
            if (pkt_valid) begin
               if (data_in[1:0] == ADDR_INVALID) begin
                  state_d = DROP;
               end else begin
                  addr_d     = data_in[1:0];
                  hdr_d      = data_in;
                  par_calc_d = data_in;
                  err_d      = 1'b0;
                  // Header may only start a FIFO that has been drained.
                  state_d    = (|(fifo_empty & dest_onehot(data_in[1:0])))
                               ? LOAD_FIRST : WAIT_EMPTY;
               end
            end
         end

         DROP: begin
            if (!pkt_valid) state_d = IDLE;
         end

         WAIT_EMPTY: begin
            if (empty_sel) state_d = LOAD_FIRST;
         end

         // Header write is issued one cycle after lfd_state so it lines up
         // with the FIFO's delayed header tag.
         LOAD_FIRST: begin
            dout_d      = hdr_q;
            write_enb_d = dest_oh;
            state_d     = LOAD_DATA;
         end

         LOAD_DATA: begin
            if (wr_blocked) begin
               state_d = FULL_STALL;
            end else begin
               dout_d      = data_in;
               write_enb_d = dest_oh;
               if (pkt_valid) begin
                  par_calc_d = par_calc_q ^ data_in;
               end else begin
                  // Parity byte is stored in the FIFO as well as checked.
                  par_rx_d = data_in;
                  state_d  = CHECK_PARITY;
               end
            end
         end

         FULL_STALL: begin
            if (wr_clear) state_d = LOAD_DATA;
         end

         CHECK_PARITY: begin
            if (wr_clear) begin
               err_d   = (par_calc_q != par_rx_q);
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d     = IDLE;
         write_enb_d = 3'b000;
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         hdr_q       <= '0;
         par_calc_q  <= '0;
         par_rx_q    <= '0;
         err_q       <= 1'b0;
         dout_q      <= '0;
         write_enb_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         hdr_q       <= hdr_d;
         par_calc_q  <= par_calc_d;
         par_rx_q    <= par_rx_d;
         err_q       <= err_d;
         dout_q      <= dout_d;
         write_enb_q <= write_enb_d;
      end
   end

   assign dout      = dout_q;
   assign write_enb = write_enb_q;
   assign err       = err_q;

endmodule

// File: tb/tb_router_ctrl.sv
module tb_router_ctrl;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic [2:0] fifo_full, fifo_empty, rd, preload;
   logic [7:0] dout;
   logic [2:0] write_enb, vld_out, soft_reset;
   logic       lfd_state, busy, err;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int occ [3];

   logic [7:0] tx [$];
   logic [7:0] wr_byte [$];
   int         wr_dest [$];
   int         wr_cyc [$];
   int         lfd_cyc [$];

   router_ctrl dut (
      .clock      (clock),
      .resetn     (resetn),
      .pkt_valid  (pkt_valid),
      .data_in    (data_in),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .read_enb   (rd),
      .dout       (dout),
      .write_enb  (write_enb),
      .lfd_state  (lfd_state),
      .busy       (busy),
      .vld_out    (vld_out),
      .soft_reset (soft_reset),
      .err        (err)
   );

   always #5 clock = ~clock;

   // Depth-16 occupancy model of the three FIFOs, plus a log of landed writes.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         fifo_full[i]  = (occ[i] >= 16);
         fifo_empty[i] = (occ[i] == 0);
      end
   end

   always @(posedge clock) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 3; i++) begin
         if (write_enb[i] && !fifo_full[i]) begin
            wr_byte.push_back(dout);
            wr_dest.push_back(i);
            wr_cyc.push_back(cyc);
         end
         if (soft_reset[i] || !resetn) occ[i] <= 0;
         else if (preload[i])          occ[i] <= 1;
         else occ[i] <= occ[i] + ((write_enb[i] && !fifo_full[i]) ? 1 : 0)
                               - ((rd[i] && !fifo_empty[i]) ? 1 : 0);
      end
   end

   always @(negedge clock) if (lfd_state) lfd_cyc.push_back(cyc);

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present tx[] honouring busy; the last byte goes out with pkt_valid low.
   task automatic send(output int stalls);
      int  i;
      int  guard;
      logic b;
      i = 0; stalls = 0; guard = 0;
      while (i < tx.size() && guard < 400) begin
         pkt_valid = (i != tx.size() - 1);
         data_in   = tx[i];
         @(negedge clock);
         b = busy;
         tick();
         if (b) stalls++;
         else   i++;
         guard++;
      end
      pkt_valid = 1'b0;
      data_in   = 8'h00;
      chk("send_done", i, tx.size());
   endtask

   task automatic check_log(input string tag, input int base, input int dest);
      chk({tag, "_nwr"}, wr_byte.size() - base, tx.size());
      for (int k = 0; k < tx.size() && base + k < wr_byte.size(); k++)
         chk($sformatf("%s_w%0d", tag, k),
             (wr_dest[base+k] << 8) | int'(wr_byte[base+k]),
             (dest << 8) | int'(tx[k]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   stalls, base, lbase, early;
      logic b, aborted;

      resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00; rd = 3'b000; preload = 3'b000;
      repeat (3) tick();
      chk("rst_dout", dout, 0);
      chk("rst_we", write_enb, 0);
      chk("rst_busy", busy, 0);
      chk("rst_lfd", lfd_state, 0);
      chk("rst_err", err, 0);
      chk("rst_sr", soft_reset, 0);
      resetn = 1'b1;
      tick();
      chk("rel_busy", busy, 0);

      // ---- good packet to address 1, FIFO1 reading -------------------
      rd = 3'b011;
      tx = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      base = wr_byte.size(); lbase = lfd_cyc.size();
      send(stalls);
      chk("t1_stalls", stalls, 1);
      tick();
      chk("t1_err", err, 0);
      chk("t1_we_idle", write_enb, 0);
      chk("t1_busy_idle", busy, 0);
      check_log("t1", base, 1);
      chk("t1_lfd_n", lfd_cyc.size() - lbase, 1);
      if (lfd_cyc.size() > lbase && wr_cyc.size() > base)
         chk("t1_lfd_align", wr_cyc[base], lfd_cyc[lbase] + 1);

      // ---- bad parity ------------------------------------------------
      tx = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C};
      base = wr_byte.size();
      send(stalls);
      tick();
      chk("t2_err", err, 1);
      check_log("t2", base, 1);
      repeat (3) tick();
      chk("t2_err_hold", err, 1);

      // ---- address 3 dropped; err untouched; next header normal -----
      tx = '{8'h07, 8'h55, 8'h66};
      base = wr_byte.size();
      send(stalls);
      chk("t5_stalls", stalls, 0);
      tick();
      chk("t5_nwr", wr_byte.size() - base, 0);
      chk("t5_err_kept", err, 1);
      tx = '{8'h09, 8'hAA, 8'h55, 8'hF6};
      base = wr_byte.size();
      send(stalls);
      tick();
      chk("t5_next_err", err, 0);
      check_log("t5n", base, 1);

      // ---- address 0, length 20, FIFO0 not read until full ---------
      rd = 3'b010;
      tx.delete();
      tx.push_back(8'h50);
      for (int k = 1; k <= 20; k++) tx.push_back(8'(k));
      tx.push_back(8'h44);
      base = wr_byte.size();
      fork
         send(stalls);
         begin
            int g;
            g = 0;
            @(negedge clock);
            while (!((wr_byte.size() - base) >= 1 && busy) && g < 100) begin
               @(negedge clock);
               g++;
            end
            chk("t3_busy_seen", (g < 100), 1);
            chk("t3_fill16", wr_byte.size() - base, 16);
            tick(); tick();
            chk("t3_hold16", wr_byte.size() - base, 16);
            rd = 3'b011;
            tick(); tick();
            rd = 3'b010;
            repeat (4) tick();
            chk("t3_two_more", wr_byte.size() - base, 18);
            chk("t3_busy_again", busy, 1);
            rd = 3'b011;
         end
      join
      tick();
      chk("t3_err", err, 0);
      check_log("t3", base, 0);

      // ---- FIFO0 occupied when header to address 0 arrives ----------
      rd = 3'b010;
      preload = 3'b001;
      tick();
      preload = 3'b000;
      tx = '{8'h04, 8'h5A, 8'h5E};
      base = wr_byte.size();
      fork
         send(stalls);
         begin
            tick();
            chk("t6_wait_busy", busy, 1);
            chk("t6_wait_lfd", lfd_state, 0);
            tick(); tick();
            chk("t6_wait_busy2", busy, 1);
            chk("t6_wait_nwr", wr_byte.size() - base, 0);
            rd = 3'b011;
         end
      join
      tick();
      check_log("t6", base, 0);
      chk("t6_err", err, 0);

      // ---- timeout on FIFO2 holding one entry -----------------------
      preload = 3'b100;
      tick();
      preload = 3'b000;
      early = 0;
      for (int n = 1; n <= 29; n++) begin
         tick();
         if (soft_reset[2]) early = 1;
      end
      chk("t4_no_early", early, 0);
      tick();
      chk("t4_pulse30", soft_reset, 3'b100);
      tick();
      chk("t4_one_cycle", soft_reset[2], 0);

      // ---- packet to address 2 aborted by timeout -------------------
      base = wr_byte.size();
      aborted = 1'b0;
      pkt_valid = 1'b1;
      data_in = 8'h7A;
      for (int c = 0; c < 100 && !aborted; c++) begin
         @(negedge clock);
         b = busy;
         tick();
         if (soft_reset[2]) begin
            aborted = 1'b1;
            pkt_valid = 1'b0;
            data_in = 8'h00;
         end else if (!b) begin
            data_in = 8'(c + 1);
         end
      end
      chk("t4_aborted", aborted, 1);
      chk("t4_abort_we", write_enb, 0);
      chk("t4_abort_busy", busy, 0);
      chk("t4_fill", wr_byte.size() - base, 16);
      tick();
      chk("t4_post_we", write_enb, 0);
      chk("t4_post_sr", soft_reset, 0);

      // ---- reset mid-payload ----------------------------------------
      pkt_valid = 1'b1;
      data_in = 8'h0D;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         b = busy;
         tick();
         if (!b) data_in = data_in + 8'h10;
      end
      chk("t7_pre_we", write_enb, 3'b010);
      #2 resetn = 1'b0;
      #1;
      pkt_valid = 1'b0;
      chk("t7_dout", dout, 0);
      chk("t7_we", write_enb, 0);
      chk("t7_busy", busy, 0);
      chk("t7_lfd", lfd_state, 0);
      chk("t7_err", err, 0);
      base = wr_byte.size();
      tick(); tick();
      resetn = 1'b1;
      repeat (3) tick();
      chk("t7_no_write", wr_byte.size() - base, 0);
      chk("t7_idle_busy", busy, 0);
      chk("t7_idle_we", write_enb, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
